// File: rtl/if_stage_if.sv
// Byte-wide read bus between the fetch stage (master) and the memory controller (slave).
interface if_stage_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_valid,
    output mem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: direct-mapped I-cache with a byte-serial miss fill.
// Raises if_stall_req while a miss is outstanding so the PC register holds.
module if_stage #(
  parameter int unsigned IDX_BITS = 7,
  parameter int unsigned TAG_BITS = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        jump_flag,
  input  logic        stall_in,
  output logic        if_stall_req,
  if_stage_if.master  mem,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  localparam int unsigned ENTRIES = 2 ** IDX_BITS;
  localparam int unsigned IDX_LO  = 2;
  localparam int unsigned IDX_HI  = IDX_BITS + 1;
  localparam int unsigned TAG_LO  = IDX_BITS + 2;
  localparam int unsigned TAG_HI  = IDX_BITS + TAG_BITS + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [31:0]         miss_pc_q, miss_pc_d;
  logic [31:0]         buf_q, buf_d;
  logic                pend_q, pend_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic                if_valid_q, if_valid_d;
  logic [31:0]         if_inst_q, if_inst_d;
  logic [31:0]         if_pc_q, if_pc_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;

  logic [31:0]         data_mem [ENTRIES];
  logic [TAG_BITS-1:0] tag_mem  [ENTRIES];

  logic [IDX_BITS-1:0] pc_idx, miss_idx;
  logic [TAG_BITS-1:0] pc_tag, miss_tag;
  logic                hit_c;
  logic                stall_req_c;
  logic                cache_we_c;
  logic [31:0]         word_c;

  assign pc_idx   = pc[IDX_HI:IDX_LO];
  assign pc_tag   = pc[TAG_HI:TAG_LO];
  assign miss_idx = miss_pc_q[IDX_HI:IDX_LO];
  assign miss_tag = miss_pc_q[TAG_HI:TAG_LO];
  assign hit_c    = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign word_c   = {mem.mem_rdata, buf_q[23:0]};

  // Stall request is combinational; forced low while reset is held.
  assign if_stall_req  = stall_req_c && rst;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_addr  = mem_addr_q;
  assign if_valid      = if_valid_q;
  assign if_inst       = if_inst_q;
  assign if_pc         = if_pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      miss_pc_q  <= 32'd0;
      buf_q      <= 32'd0;
      pend_q     <= 1'b0;
      valid_q    <= '0;
      if_valid_q <= 1'b0;
      if_inst_q  <= 32'd0;
      if_pc_q    <= 32'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_pc_q  <= miss_pc_d;
      buf_q      <= buf_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Cache storage is not reset; the valid bits alone qualify a line.
  always_ff @(posedge clk) begin
    if (cache_we_c) begin
      data_mem[miss_idx] <= word_c;
      tag_mem[miss_idx]  <= miss_tag;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    miss_pc_d   = miss_pc_q;
    buf_d       = buf_q;
    pend_d      = pend_q;
    valid_d     = valid_q;
    if_valid_d  = if_valid_q;
    if_inst_d   = if_inst_q;
    if_pc_d     = if_pc_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    stall_req_c = 1'b0;
    cache_we_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (jump_flag) begin
          if_valid_d = 1'b0;
          pend_d     = 1'b0;
        end else if (stall_in) begin
          // downstream stalled: hold everything
        end else if (pend_q) begin
          // a fill finished under stall; present it before any new lookup
          if_valid_d = 1'b1;
          if_inst_d  = buf_q;
          if_pc_d    = miss_pc_q;
          pend_d     = 1'b0;
        end else if (hit_c) begin
          if_valid_d = 1'b1;
          if_inst_d  = data_mem[pc_idx];
          if_pc_d    = pc;
        end else begin
          stall_req_c = 1'b1;
          state_d     = FILL;
          miss_pc_d   = pc;
          cnt_d       = 2'd0;
          mem_req_d   = 1'b1;
          mem_addr_d  = pc;
          if_valid_d  = 1'b0;
        end
      end

      FILL: begin
        stall_req_c = 1'b1;
        if (jump_flag) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_valid_d = 1'b0;
          cnt_d      = 2'd0;
        end else if (mem.mem_valid) begin
          buf_d[{cnt_q, 3'b000} +: 8] = mem.mem_rdata;
          if (cnt_q == 2'd3) begin
            cache_we_c        = 1'b1;
            valid_d[miss_idx] = 1'b1;
            state_d           = IDLE;
            mem_req_d         = 1'b0;
            cnt_d             = 2'd0;
            if (stall_in) begin
              pend_d = 1'b1;
            end else begin
              if_valid_d = 1'b1;
              if_inst_d  = word_c;
              if_pc_d    = miss_pc_q;
            end
          end else begin
            cnt_d      = cnt_q + 2'd1;
            mem_addr_d = mem_addr_q + 32'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/if_stage.md
Name:
if_stage

Overview:
- Instruction-fetch stage directly downstream of the PC/branch-prediction register. Consumes `pc` each cycle and returns the 32-bit instruction word to the IF/ID latch.
- Holds a direct-mapped instruction cache. On a miss it fills one word from the byte-wide memory controller and raises a stall request, so the PC register holds (`stall_signal[0]`) until the word arrives.

Parameters:
- IDX_BITS, 7, cache index width (entries = 2^IDX_BITS); index = pc[IDX_BITS+1:2]
- TAG_BITS, 9, stored tag width; tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (rst==0 resets immediately, independent of clk)
- pc  in  32  fetch address from PC register, word aligned
- jump_flag  in  1  mispredict/jump flush from EX; discards current fetch
- stall_in  in  1  downstream (ID) stall; hold outputs
- if_stall_req  out  1  to stall controller; high while a miss is outstanding
- mem_req  out  1  byte-read request to memory controller
- mem_addr  out  32  byte address of requested byte
- mem_valid  in  1  mem_rdata holds the byte for current mem_addr
- mem_rdata  in  8  returned byte
- if_valid  out  1  if_inst/if_pc hold a valid instruction
- if_inst  out  32  fetched instruction
- if_pc  out  32  address of if_inst

Behaviour:
- Reset (rst==0, async):
  - all valid bits cleared; FSM=IDLE; byte counter=0.
  - if_valid=0, if_inst=0, if_pc=0, mem_req=0, mem_addr=0, if_stall_req=0.
  - Cache data/tag arrays need not be cleared.
- Cache lookup is combinational on pc: hit = valid[idx] && tag[idx]==pc tag field.
- FSM states: IDLE, FILL.
- IDLE, priority order:
  - jump_flag: if_valid<=0; no lookup.
  - else stall_in: outputs hold.
  - else hit: next edge if_valid<=1, if_inst<=data[idx], if_pc<=pc. Hit latency is 1 cycle, back-to-back hits every cycle.
  - else miss:
    - if_stall_req=1 combinationally in the same cycle.
    - next edge: FSM<=FILL, miss_pc<=pc, cnt<=0, mem_req<=1, mem_addr<=pc, if_valid<=0.
- FILL:
  - mem_req=1 held; if_stall_req=1 held; mem_addr = miss_pc + cnt.
  - Each cycle with mem_valid, byte goes to buf[8*cnt+7:8*cnt] (little-endian) and cnt increments. Gaps between mem_valid are allowed.
  - When the 4th byte arrives (cnt==3 && mem_valid), next edge:
    - write data/tag/valid at miss_pc index; overwrite any previous line.
    - if_inst<=assembled word; if_pc<=miss_pc; if_valid<=1.
    - mem_req<=0; FSM<=IDLE; if_stall_req low from the following cycle.
  - Miss latency = 1 + 4 byte returns (minimum 5 cycles with mem_valid every cycle).
- jump_flag in FILL:
  - abort at next edge: FSM<=IDLE, mem_req<=0, if_valid<=0; partial buffer discarded.
  - Cache not written. if_stall_req drops the cycle after.
  - jump_flag has priority over a simultaneous 4th-byte mem_valid: that word is dropped and not written.
- mem_valid while FSM==IDLE is ignored.
- stall_in during FILL:
  - the fill continues.
  - On completion the cache is written but the output latch is updated only when stall_in==0. Until then the word sits in a pending register and is presented on the first cycle with stall_in==0.
- Reset asserted mid-FILL: immediate return to IDLE with mem_req=0. The memory controller must tolerate a dropped request.
- Tag compare uses only the TAG_BITS field; addresses differing above bit IDX_BITS+TAG_BITS+1 alias (accepted).
- if_stall_req never asserts on a hit or while jump_flag is high in IDLE.

Test Plan:
- Cold miss:
  - Stimulus: reset, pc=0x00000000; memory returns bytes 0x13,0x00,0x00,0x00 on consecutive cycles.
  - Required: mem_addr steps 0,1,2,3; if_stall_req high 5 cycles; if_valid=1 with if_inst=0x00000013, if_pc=0.
- Hit:
  - Stimulus: after the cold miss, present pc=0x0 again.
  - Required: if_valid next cycle, if_inst=0x00000013; no mem_req, no if_stall_req.
- Conflict eviction:
  - Stimulus: fill pc=0x4, then pc=0x204 (same index, tag differs), then pc=0x4.
  - Required: all three miss; the final fetch re-issues mem_addr 0x4..0x7.
- Flush mid-fill:
  - Stimulus: miss at pc=0x8; assert jump_flag after 2 bytes; then pc=0x8 again.
  - Required: mem_req drops; if_valid=0; the later fetch misses again (line not written).
- Gapped memory + downstream stall:
  - Stimulus: mem_valid every other cycle; stall_in=1 when the last byte lands, released 3 cycles later.
  - Required: if_valid rises only the cycle after release, with the correct word.
- Async reset:
  - Stimulus: drop rst mid-FILL between clock edges.
  - Required: mem_req, if_valid, if_stall_req go 0 immediately; a subsequent fetch of the same pc misses.
